// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ctrl bit map,
// stage occupancy states and EX->MEM payload.
package pipe_pkg;

  localparam int P_XLEN       = 32;
  localparam int P_REG_ADDR_W = 5;
  localparam int P_CTRL_W     = 4;

  localparam int MEM_READ  = 3;
  localparam int MEM_WRITE = 2;
  localparam int REG_WRITE = 1;
  localparam int WB_SEL    = 0;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } stage_state_e;

  typedef struct packed {
    logic [P_XLEN-1:0]       alu_out;
    logic [P_XLEN-1:0]       store_data;
    logic [P_REG_ADDR_W-1:0] rd;
    logic [P_CTRL_W-1:0]     ctrl;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Valid/ready beat carrying the EX->MEM payload.
// master drives the beat, slave returns ready.
interface ex_mem_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4
);
  logic                  valid;
  logic                  ready;
  logic [XLEN-1:0]       alu_out;
  logic [XLEN-1:0]       store_data;
  logic [REG_ADDR_W-1:0] rd;
  logic [CTRL_W-1:0]     ctrl;

  modport master (
    output valid, alu_out, store_data, rd, ctrl,
    input  ready
  );

  modport slave (
    input  valid, alu_out, store_data, rd, ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter, cleared only by reset.
// Used for back-pressure statistics.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM boundary register with optional
// 2-entry skid buffer, flush and stall counter.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4,
  parameter bit SKID_EN    = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  ex_mem_stage_if.slave    up,
  ex_mem_stage_if.master   dn,
  output logic             out_rd_wen,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]       alu_out;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic [CTRL_W-1:0]     ctrl;
  } pl_t;

  pl_t  in_pl;
  pl_t  main_q;
  logic out_valid;
  logic accept;
  logic retire;

  assign in_pl = '{
    alu_out:    up.alu_out,
    store_data: up.store_data,
    rd:         up.rd,
    ctrl:       up.ctrl
  };

  assign accept = up.valid & up.ready;
  assign retire = out_valid & dn.ready;

  assign dn.valid      = out_valid;
  assign dn.alu_out    = main_q.alu_out;
  assign dn.store_data = main_q.store_data;
  assign dn.rd         = main_q.rd;
  assign dn.ctrl       = main_q.ctrl;

  assign out_rd_wen = out_valid
                    & main_q.ctrl[REG_WRITE]
                    & (main_q.rd != '0);

  generate
    if (SKID_EN) begin : g_skid
      stage_state_e state_q;
      pl_t          skid_q;
      logic         vld_q;
      logic         rdy_q;

      // occupancy FSM; ready/valid registered with state
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end else if (flush_i) begin
          state_q <= EMPTY;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                main_q  <= in_pl;
                state_q <= FULL;
                vld_q   <= 1'b1;
              end
            end
            FULL: begin
              if (accept && retire) begin
                main_q <= in_pl;
              end else if (accept) begin
                skid_q  <= in_pl;
                state_q <= SKID;
                rdy_q   <= 1'b0;
              end else if (retire) begin
                state_q <= EMPTY;
                vld_q   <= 1'b0;
              end
            end
            SKID: begin
              if (retire) begin
                main_q  <= skid_q;
                state_q <= FULL;
                rdy_q   <= 1'b1;
              end
            end
            default: begin
              state_q <= EMPTY;
              vld_q   <= 1'b0;
              rdy_q   <= 1'b1;
            end
          endcase
        end
      end

      assign up.ready  = rdy_q;
      assign out_valid = vld_q;
    end else begin : g_single
      logic vld_q;

      // single holding register, ready passes through
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_q <= '0;
          vld_q  <= 1'b0;
        end else if (flush_i) begin
          vld_q <= 1'b0;
        end else if (accept) begin
          main_q <= in_pl;
          vld_q  <= 1'b1;
        end else if (retire) begin
          vld_q <= 1'b0;
        end
      end

      assign up.ready  = ~vld_q | dn.ready;
      assign out_valid = vld_q;
    end
  endgenerate

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~dn.ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: skid and
// single-entry builds side by side.
module tb_ex_mem_stage;
  import pipe_pkg::*;

  localparam logic [3:0] RW = 4'(1 << REG_WRITE);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fl_a, fl_b;
  logic        wen_a, wen_b;
  logic [15:0] sc_a;
  logic [1:0]  sc_b;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(4)) ua ();
  ex_mem_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(4)) da ();
  ex_mem_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(4)) ub ();
  ex_mem_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(4)) db ();

  ex_mem_stage #(
    .XLEN(32), .REG_ADDR_W(5), .CTRL_W(4),
    .SKID_EN(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_a),
    .up(ua), .dn(da),
    .out_rd_wen(wen_a), .stall_cnt(sc_a)
  );

  ex_mem_stage #(
    .XLEN(32), .REG_ADDR_W(5), .CTRL_W(4),
    .SKID_EN(1'b0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_b),
    .up(ub), .dn(db),
    .out_rd_wen(wen_b), .stall_cnt(sc_b)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic [4:0]  ird;
    logic [3:0]  ictrl;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ea;
    logic        erw;
    logic        eir;
    logic [15:0] esc;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(
    input logic iv, input int ia, input int ird,
    input logic [3:0] ictrl, input logic ordy,
    input logic fl, input logic ev, input int ea,
    input logic erw, input logic eir, input int esc
  );
    vec_t v;
    v.iv = iv; v.ia = ia; v.ird = ird[4:0];
    v.ictrl = ictrl; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ea = ea; v.erw = erw;
    v.eir = eir; v.esc = esc[15:0];
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_all();
    ua.valid = 0; ua.alu_out = 0; ua.store_data = 0;
    ua.rd = 0; ua.ctrl = 0; da.ready = 0; fl_a = 0;
    ub.valid = 0; ub.alu_out = 0; ub.store_data = 0;
    ub.rd = 0; ub.ctrl = 0; db.ready = 0; fl_b = 0;
  endtask

  task automatic run(input bit sel, input vec_t v,
                     input int idx);
    logic        ov, ir, rw;
    logic [31:0] oa, osd;
    logic [15:0] sc;
    string       tg;
    if (!sel) begin
      ua.valid = v.iv; ua.alu_out = v.ia;
      ua.store_data = ~v.ia; ua.rd = v.ird;
      ua.ctrl = v.ictrl; da.ready = v.ordy;
      fl_a = v.fl;
    end else begin
      ub.valid = v.iv; ub.alu_out = v.ia;
      ub.store_data = ~v.ia; ub.rd = v.ird;
      ub.ctrl = v.ictrl; db.ready = v.ordy;
      fl_b = v.fl;
    end
    @(negedge clk);
    if (!sel) begin
      ov = da.valid; ir = ua.ready; rw = wen_a;
      oa = da.alu_out; osd = da.store_data; sc = sc_a;
    end else begin
      ov = db.valid; ir = ub.ready; rw = wen_b;
      oa = db.alu_out; osd = db.store_data;
      sc = {14'b0, sc_b};
    end
    tg = $sformatf("%s[%0d]", sel ? "b" : "a", idx);
    chk({tg, " out_valid"}, 32'(ov), 32'(v.ev));
    chk({tg, " in_ready"}, 32'(ir), 32'(v.eir));
    chk({tg, " rd_wen"}, 32'(rw), 32'(v.erw));
    chk({tg, " stall_cnt"}, 32'(sc), 32'(v.esc));
    if (v.ev) begin
      chk({tg, " alu_out"}, oa, v.ea);
      chk({tg, " store_data"}, osd, ~v.ea);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // streaming 0..9, one-cycle latency, rd=k
    for (int k = 0; k < 10; k++)
      va.push_back(mk(1, k, k, RW, 1, 0,
                      k > 0, k - 1, k > 1, 1, 0));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 9, 1, 1, 0));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    // back-pressure A=20 B=21 C=22
    va.push_back(mk(1, 20, 1, RW, 1, 0, 0,  0, 0, 1, 0));
    va.push_back(mk(1, 21, 1, RW, 0, 0, 1, 20, 1, 1, 0));
    va.push_back(mk(1, 22, 1, RW, 0, 0, 1, 20, 1, 0, 1));
    va.push_back(mk(1, 22, 1, RW, 0, 0, 1, 20, 1, 0, 2));
    va.push_back(mk(1, 22, 1, RW, 1, 0, 1, 20, 1, 0, 3));
    va.push_back(mk(1, 22, 1, RW, 1, 0, 1, 21, 1, 1, 3));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 22, 1, 1, 3));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 3));
    // flush from SKID with D offered, then E alone
    va.push_back(mk(1, 30, 1, RW, 0, 0, 0,  0, 0, 1, 3));
    va.push_back(mk(1, 31, 1, RW, 0, 0, 1, 30, 1, 1, 3));
    va.push_back(mk(1, 32, 1, RW, 0, 1, 1, 30, 1, 0, 4));
    va.push_back(mk(1, 33, 1, RW, 0, 0, 0,  0, 0, 1, 5));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 33, 1, 1, 5));
    // flush from FULL drops a beat accepted that cycle
    va.push_back(mk(1, 34, 1, RW, 1, 0, 0,  0, 0, 1, 5));
    va.push_back(mk(1, 35, 1, RW, 0, 1, 1, 34, 1, 1, 5));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 6));
    // forwarding hint
    va.push_back(mk(1, 40, 0, RW, 1, 0, 0,  0, 0, 1, 6));
    va.push_back(mk(1, 41, 5, RW, 1, 0, 1, 40, 0, 1, 6));
    va.push_back(mk(1, 42, 5, 0,  1, 0, 1, 41, 1, 1, 6));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 42, 0, 1, 6));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 6));
    // single-entry build, 2-bit counter saturates
    vb.push_back(mk(1, 20, 1, RW, 1, 0, 0,  0, 0, 1, 0));
    vb.push_back(mk(1, 21, 1, RW, 0, 0, 1, 20, 1, 0, 0));
    vb.push_back(mk(1, 21, 1, RW, 0, 0, 1, 20, 1, 0, 1));
    vb.push_back(mk(1, 21, 1, RW, 0, 0, 1, 20, 1, 0, 2));
    vb.push_back(mk(1, 21, 1, RW, 0, 0, 1, 20, 1, 0, 3));
    vb.push_back(mk(1, 21, 1, RW, 1, 0, 1, 20, 1, 1, 3));
    vb.push_back(mk(1, 22, 1, RW, 1, 0, 1, 21, 1, 1, 3));
    vb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 22, 1, 1, 3));
    vb.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3));

    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst a out_valid", 32'(da.valid), 0);
    chk("rst a in_ready", 32'(ua.ready), 1);
    chk("rst a stall_cnt", 32'(sc_a), 0);
    chk("rst a rd_wen", 32'(wen_a), 0);
    chk("rst b out_valid", 32'(db.valid), 0);
    chk("rst b in_ready", 32'(ub.ready), 1);

    foreach (va[i]) run(1'b0, va[i], i);
    idle_all();
    foreach (vb[i]) run(1'b1, vb[i], i);
    idle_all();

    // async reset mid-stream with the skid entry in use
    ua.valid = 1; ua.alu_out = 50; ua.store_data = 0;
    ua.rd = 3; ua.ctrl = RW; da.ready = 0;
    @(posedge clk); #1;
    ua.alu_out = 51;
    @(posedge clk); #1;
    ua.alu_out = 52;
    chk("pre-rst in_ready", 32'(ua.ready), 0);
    chk("pre-rst out_valid", 32'(da.valid), 1);
    chk("pre-rst stall_cnt", 32'(sc_a), 7);
    #2;
    rst_n = 1'b0;
    fl_a = 1'b1;
    #1;
    chk("async rst out_valid", 32'(da.valid), 0);
    chk("async rst stall_cnt", 32'(sc_a), 0);
    chk("async rst in_ready", 32'(ua.ready), 1);
    chk("async rst rd_wen", 32'(wen_a), 0);
    ua.valid = 0;
    fl_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst out_valid", 32'(da.valid), 0);
    chk("post-rst in_ready", 32'(ua.ready), 1);
    ua.valid = 1; ua.alu_out = 60; da.ready = 1;
    @(posedge clk); #1;
    ua.valid = 0;
    chk("post-rst beat valid", 32'(da.valid), 1);
    chk("post-rst beat alu", da.alu_out, 60);
    @(posedge clk); #1;
    chk("post-rst drain", 32'(da.valid), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
